// File: rtl/vfp_pattern_gen.sv
// vfp_pattern_gen: raster test-pattern video source with run-time geometry, blanking,
// frame count, stop control and downstream backpressure.
module vfp_pattern_gen #(
  parameter int DATA_WIDTH = 8,
  parameter int CHANNELS   = 3,
  parameter int COORD_W    = 12,
  parameter int FRAME_W    = 16,
  parameter int CHK_SHIFT  = 3
) (
  input  logic                           clk,
  input  logic                           rst_l,
  input  logic                           start,
  input  logic                           stop,
  input  logic [2:0]                     mode,
  input  logic [COORD_W-1:0]             cfg_width,
  input  logic [COORD_W-1:0]             cfg_height,
  input  logic [COORD_W-1:0]             cfg_hblank,
  input  logic [COORD_W-1:0]             cfg_vblank,
  input  logic [FRAME_W-1:0]             cfg_frames,
  input  logic [CHANNELS*DATA_WIDTH-1:0] cfg_color,
  input  logic                           ready,
  output logic                           valid,
  output logic                           lvalid,
  output logic                           fvalid,
  output logic                           sof,
  output logic                           eof,
  output logic [COORD_W-1:0]             x,
  output logic [COORD_W-1:0]             y,
  output logic [CHANNELS*DATA_WIDTH-1:0] pixel,
  output logic                           busy,
  output logic                           done,
  output logic                           cfg_err,
  output logic [FRAME_W-1:0]             frame_cnt
);
  localparam int PW = CHANNELS * DATA_WIDTH;
  localparam int SW = (COORD_W + 2 > DATA_WIDTH) ? COORD_W + 2 : DATA_WIDTH;
  typedef enum logic [2:0] {IDLE, VBLANK, HBLANK, ACTIVE, DONE} state_t;
  state_t state, nxt;
  logic [COORD_W-1:0] w_r, h_r, hb_r, vb_r, xc, yc, bcnt;
  logic [FRAME_W-1:0] frames_r;
  logic [PW-1:0] color_r, pix_n;
  logic [2:0] mode_r;
  logic [SW-1:0] xs, ys;
  logic bad, go, accept, eol, last_px, last_frame, stop_pend, stop_now, chk;

  assign bad = cfg_width == '0 || cfg_height == '0;
  assign go = state == IDLE && start && !bad;
  assign accept = state == ACTIVE && ready;
  assign eol = xc == w_r - COORD_W'(1);
  assign last_px = eol && yc == h_r - COORD_W'(1);
  assign last_frame = frames_r != '0 && frame_cnt + FRAME_W'(1) == frames_r;
  assign stop_now = stop_pend || stop;
  assign xs = SW'(xc);
  assign ys = SW'(yc);
  assign chk = xc[CHK_SHIFT] ^ yc[CHK_SHIFT];

  // VBLANK spends one extra cycle so a zero vblank still gives a setup cycle after start
  always_comb begin
    nxt = state;
    case (state)
      IDLE:    nxt = go ? VBLANK : IDLE;
      VBLANK:  nxt = stop_now ? DONE : bcnt < vb_r ? VBLANK : hb_r == '0 ? ACTIVE : HBLANK;
      HBLANK:  nxt = bcnt == hb_r - COORD_W'(1) ? ACTIVE : HBLANK;
      ACTIVE:  nxt = !(accept && eol) ? ACTIVE :
                     !last_px ? (hb_r == '0 ? ACTIVE : HBLANK) :
                     (last_frame || stop_now) ? DONE : VBLANK;
      DONE:    nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  always_comb begin
    pix_n = '0;
    for (int c = 0; c < CHANNELS; c++)
      pix_n[c*DATA_WIDTH +: DATA_WIDTH] =
        mode_r == 3'd0 ? DATA_WIDTH'(xs + ys + SW'(c)) :
        (mode_r == 3'd1 || (mode_r == 3'd4 && chk)) ? color_r[c*DATA_WIDTH +: DATA_WIDTH] :
        mode_r == 3'd2 ? xs[DATA_WIDTH-1:0] :
        mode_r == 3'd3 ? ys[DATA_WIDTH-1:0] : '0;
  end

  always_ff @(posedge clk or negedge rst_l)
    if (!rst_l) state <= IDLE;
    else state <= nxt;

  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      {w_r, h_r, hb_r, vb_r, frames_r, color_r, mode_r} <= '0;
      {xc, yc, bcnt, stop_pend} <= '0;
      {valid, lvalid, fvalid, sof, eof, busy, done, cfg_err} <= '0;
      {x, y, pixel, frame_cnt} <= '0;
    end else begin
      bcnt <= state != nxt ? '0 : bcnt + COORD_W'(1);
      stop_pend <= state != IDLE && stop_now;
      valid <= accept;
      lvalid <= state == ACTIVE;
      fvalid <= accept || (fvalid && !eof);
      busy <= nxt != IDLE;
      done <= state == DONE;
      cfg_err <= state == IDLE && start && bad;
      if (go) begin
        w_r <= cfg_width;
        h_r <= cfg_height;
        hb_r <= cfg_hblank;
        vb_r <= cfg_vblank;
        frames_r <= cfg_frames;
        color_r <= cfg_color;
        mode_r <= mode;
        xc <= '0;
        yc <= '0;
        frame_cnt <= '0;
      end
      if (accept) begin
        x <= xc;
        y <= yc;
        pixel <= pix_n;
        sof <= xc == '0 && yc == '0;
        eof <= last_px;
        xc <= eol ? '0 : xc + COORD_W'(1);
        yc <= last_px ? '0 : eol ? yc + COORD_W'(1) : yc;
        frame_cnt <= last_px ? frame_cnt + FRAME_W'(1) : frame_cnt;
      end
    end
  end
endmodule

// File: tb/tb_vfp_pattern_gen.sv
// tb_vfp_pattern_gen: directed and randomized checks of vfp_pattern_gen against
// a frame-level pixel model (raster order, pattern formulas, timing rules).
module tb_vfp_pattern_gen;
  localparam int CW = 12, FW = 16, PW = 24;
  logic clk = 0, rst_l = 1, start = 0, stop = 0, ready = 1;
  logic [2:0] mode = 0;
  logic [CW-1:0] cfg_width = 0, cfg_height = 0, cfg_hblank = 0, cfg_vblank = 0;
  logic [FW-1:0] cfg_frames = 0;
  logic [PW-1:0] cfg_color = 0;
  logic valid, lvalid, fvalid, sof, eof, busy, done, cfg_err;
  logic [CW-1:0] x, y;
  logic [PW-1:0] pixel;
  logic [FW-1:0] frame_cnt;
  int n_chk = 0, n_fail = 0;

  typedef struct {logic [CW-1:0] x, y; logic [PW-1:0] p; logic s, e;} px_t;

  always #5 clk = ~clk;

  vfp_pattern_gen dut (
    .clk(clk), .rst_l(rst_l), .start(start), .stop(stop), .mode(mode),
    .cfg_width(cfg_width), .cfg_height(cfg_height), .cfg_hblank(cfg_hblank),
    .cfg_vblank(cfg_vblank), .cfg_frames(cfg_frames), .cfg_color(cfg_color),
    .ready(ready), .valid(valid), .lvalid(lvalid), .fvalid(fvalid), .sof(sof),
    .eof(eof), .x(x), .y(y), .pixel(pixel), .busy(busy), .done(done),
    .cfg_err(cfg_err), .frame_cnt(frame_cnt)
  );

  function automatic logic [PW-1:0] ref_pix(input int md, input logic [PW-1:0] col, input int px, input int py);
    logic [PW-1:0] r;
    int v;
    r = '0;
    for (int c = 0; c < 3; c++) begin
      case (md)
        0: v = (px + py + c) % 256;
        1: v = int'((col >> (8 * c)) & 24'hFF);
        2: v = px % 256;
        3: v = py % 256;
        4: v = ((px / 8 + py / 8) % 2 == 1) ? int'((col >> (8 * c)) & 24'hFF) : 0;
        default: v = 0;
      endcase
      r = r | (PW'(v) << (8 * c));
    end
    return r;
  endfunction

  task automatic setup(input int w, h, hb, vb, fr, md, input logic [PW-1:0] col);
    cfg_width = CW'(w);
    cfg_height = CW'(h);
    cfg_hblank = CW'(hb);
    cfg_vblank = CW'(vb);
    cfg_frames = FW'(fr);
    mode = 3'(md);
    cfg_color = col;
  endtask

  // start is sampled at the edge right after it rises; callers then count negedges from k=0
  task automatic kick();
    @(negedge clk);
    start = 1;
    @(posedge clk);
    #1 start = 0;
  endtask

  task automatic test_reset();
    int k;
    logic seen;
    #2 rst_l = 0;
    repeat (2) @(negedge clk);
    n_chk++;
    if ({valid, lvalid, fvalid, sof, eof, busy, done, cfg_err, x, y, pixel, frame_cnt} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: got %h required 0", {valid, lvalid, fvalid, sof, eof, busy, done, cfg_err, x, y, pixel, frame_cnt});
    end
    @(negedge clk) rst_l = 1;
    setup(4, 2, 0, 0, 1, 0, '0);
    ready = 1;
    kick();
    k = 0;
    while (!valid && k < 20) begin
      @(negedge clk);
      k++;
    end
    n_chk++;
    if (valid !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_wait_valid: got valid=%b required 1 within 20 cycles", valid);
    end
    #2 rst_l = 0;
    #1;
    n_chk++;
    if ({valid, lvalid, fvalid, sof, eof, busy, done, cfg_err, x, y, pixel, frame_cnt} !== '0) begin
      n_fail++;
      $display("FAIL reset_midframe: got %h required 0", {valid, lvalid, fvalid, sof, eof, busy, done, cfg_err, x, y, pixel, frame_cnt});
    end
    seen = 0;
    repeat (4) begin
      @(negedge clk);
      seen = seen | eof | busy | valid;
    end
    n_chk++;
    if (seen !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_held_quiet: got activity=%b required 0", seen);
    end
    rst_l = 1;
  endtask

  task automatic test_basic();
    int first, nv, last_k, done_k, ndone, ex, ey;
    setup(4, 2, 0, 0, 1, 0, 24'h123456);
    ready = 1;
    kick();
    first = -1; nv = 0; last_k = -1; done_k = -1; ndone = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (valid) begin
        if (first < 0) first = k;
        ex = nv % 4;
        ey = nv / 4;
        n_chk++;
        if ({x, y, pixel, sof, eof} !== {CW'(ex), CW'(ey), ref_pix(0, 24'h123456, ex, ey), nv == 0, nv == 7}) begin
          n_fail++;
          $display("FAIL basic_pixel %0d: got x=%0d y=%0d p=%h sof=%b eof=%b required x=%0d y=%0d p=%h", nv, x, y, pixel, sof, eof, ex, ey, ref_pix(0, 24'h123456, ex, ey));
        end
        nv++;
        last_k = k;
      end
      if (done) begin
        ndone++;
        done_k = k;
      end
    end
    n_chk++;
    if (first != 2) begin n_fail++; $display("FAIL basic_latency: got %0d required 2", first); end
    n_chk++;
    if (nv != 8) begin n_fail++; $display("FAIL basic_count: got %0d required 8", nv); end
    n_chk++;
    if (ndone != 1 || done_k != last_k + 1) begin
      n_fail++;
      $display("FAIL basic_done: got %0d pulses at %0d required 1 at %0d", ndone, done_k, last_k + 1);
    end
    n_chk++;
    if ({frame_cnt, busy} !== {FW'(1), 1'b0}) begin
      n_fail++;
      $display("FAIL basic_end: got frame_cnt=%0d busy=%b required 1 0", frame_cnt, busy);
    end
  endtask

  task automatic test_blanking();
    int first, last, nv, gap, fv_low;
    logic lv [40];
    logic fv [40];
    setup(3, 2, 2, 5, 1, 2, '0);
    ready = 1;
    kick();
    first = -1; last = -1; nv = 0; gap = 0; fv_low = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      lv[k] = lvalid;
      fv[k] = fvalid;
      if (valid) begin
        if (first < 0) first = k;
        last = k;
        nv++;
      end
    end
    if (first >= 0)
      for (int k = first; k <= last; k++) begin
        if (!lv[k]) gap++;
        if (!fv[k]) fv_low++;
      end
    n_chk++;
    if (first != 9) begin n_fail++; $display("FAIL blank_latency: got %0d required 9", first); end
    n_chk++;
    if (nv != 6 || last - first != 7) begin
      n_fail++;
      $display("FAIL blank_count: got %0d pixels over span %0d required 6 over 7", nv, last - first);
    end
    n_chk++;
    if (gap != 2) begin n_fail++; $display("FAIL blank_line_gap: got %0d required 2", gap); end
    n_chk++;
    if (fv_low != 0) begin n_fail++; $display("FAIL blank_fvalid: got %0d low cycles required 0", fv_low); end
    if (last >= 0 && last + 1 < 40) begin
      n_chk++;
      if (fv[last+1] !== 1'b0) begin n_fail++; $display("FAIL blank_fvalid_after_eof: got %b required 0", fv[last+1]); end
    end
  endtask

  task automatic test_backpressure();
    int pat [7] = '{1, 0, 0, 1, 1, 0, 1};
    int nv;
    logic [CW-1:0] last_x;
    setup(4, 1, 0, 0, 1, 2, '0);
    ready = 1;
    kick();
    nv = 0;
    last_x = '0;
    for (int k = 0; k < 15; k++) begin
      @(negedge clk);
      if (k >= 2 && k <= 8) begin
        n_chk++;
        if ({valid, lvalid} !== {pat[k-2] != 0, 1'b1}) begin
          n_fail++;
          $display("FAIL bp_valid k=%0d: got valid=%b lvalid=%b required %0d 1", k, valid, lvalid, pat[k-2]);
        end
      end
      if (valid) begin
        n_chk++;
        if ({x, pixel, eof} !== {CW'(nv), ref_pix(2, '0, nv, 0), nv == 3}) begin
          n_fail++;
          $display("FAIL bp_pixel %0d: got x=%0d p=%h eof=%b required x=%0d", nv, x, pixel, eof, nv);
        end
        nv++;
        last_x = x;
      end else if (k >= 2 && k <= 8) begin
        n_chk++;
        if (x !== last_x) begin n_fail++; $display("FAIL bp_hold k=%0d: got x=%0d required %0d", k, x, last_x); end
      end
      ready = (k >= 1 && k <= 7) ? pat[k-1] != 0 : 1'b1;
    end
    n_chk++;
    if (nv != 4) begin n_fail++; $display("FAIL bp_count: got %0d required 4", nv); end
    ready = 1;
  endtask

  task automatic test_patterns();
    logic [PW-1:0] img [16][16];
    int nv, md;
    for (int pass = 0; pass < 2; pass++) begin
      md = pass == 0 ? 4 : 0;
      for (int i = 0; i < 16; i++)
        for (int j = 0; j < 16; j++) img[i][j] = '1;
      setup(16, 16, 0, 0, 1, md, 24'hFF00FF);
      ready = 1;
      kick();
      nv = 0;
      for (int k = 0; k < 400; k++) begin
        @(negedge clk);
        if (valid && x < 16 && y < 16) begin
          img[y][x] = pixel;
          nv++;
        end
        if (done) break;
      end
      n_chk++;
      if (nv != 256) begin n_fail++; $display("FAIL pat_count mode %0d: got %0d required 256", md, nv); end
      for (int yy = 0; yy < 16; yy++)
        for (int xx = 0; xx < 16; xx++) begin
          n_chk++;
          if (img[yy][xx] !== ref_pix(md, 24'hFF00FF, xx, yy)) begin
            n_fail++;
            $display("FAIL pat_pixel mode %0d (%0d,%0d): got %h required %h", md, xx, yy, img[yy][xx], ref_pix(md, 24'hFF00FF, xx, yy));
          end
        end
      if (pass == 0) begin
        n_chk++;
        if ({img[0][0], img[0][8], img[8][8]} !== {24'h0, 24'hFF00FF, 24'h0}) begin
          n_fail++;
          $display("FAIL pat_checker_points: got %h %h %h required 0 ff00ff 0", img[0][0], img[0][8], img[8][8]);
        end
      end else begin
        n_chk++;
        if (img[7][5] !== 24'h0E0D0C) begin n_fail++; $display("FAIL pat_inc_5_7: got %h required 0e0d0c", img[7][5]); end
      end
    end
  endtask

  task automatic test_stop();
    int neof, nsof, done_k;
    logic stopped;
    setup(2, 2, 0, 0, 0, 0, 24'h0A0B0C);
    ready = 1;
    kick();
    neof = 0; nsof = 0; done_k = -1; stopped = 0;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      stop = 0;
      if (done) begin
        done_k = k;
        break;
      end
      if (valid && sof) nsof++;
      if (valid && eof) begin
        neof++;
        n_chk++;
        if (frame_cnt !== FW'(neof)) begin n_fail++; $display("FAIL stop_frame_cnt: got %0d required %0d", frame_cnt, neof); end
      end
      if (nsof == 3 && !stopped) begin
        stop = 1;
        stopped = 1;
      end
    end
    stop = 0;
    n_chk++;
    if (done_k < 0 || neof != 3) begin n_fail++; $display("FAIL stop_frames: got %0d eofs done_at=%0d required 3 and done", neof, done_k); end
    n_chk++;
    if ({frame_cnt, busy} !== {FW'(3), 1'b0}) begin
      n_fail++;
      $display("FAIL stop_end: got frame_cnt=%0d busy=%b required 3 0", frame_cnt, busy);
    end
  endtask

  task automatic test_stop_vblank();
    int nv, done_k;
    setup(2, 2, 0, 5, 0, 0, '0);
    ready = 1;
    kick();
    nv = 0; done_k = -1;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      stop = k == 1;
      if (valid) nv++;
      if (done && done_k < 0) done_k = k;
    end
    stop = 0;
    n_chk++;
    if (nv != 0 || done_k != 3) begin n_fail++; $display("FAIL stop_vblank: got %0d pixels done_at=%0d required 0 and 3", nv, done_k); end
    n_chk++;
    if (frame_cnt !== '0) begin n_fail++; $display("FAIL stop_vblank_cnt: got %0d required 0", frame_cnt); end
  endtask

  task automatic test_cfg_err();
    for (int i = 0; i < 2; i++) begin
      setup(i == 0 ? 0 : 3, i == 0 ? 3 : 0, 0, 0, 1, 0, '0);
      kick();
      for (int k = 0; k < 5; k++) begin
        @(negedge clk);
        n_chk++;
        if ({cfg_err, busy} !== {k == 0, 1'b0}) begin
          n_fail++;
          $display("FAIL cfg_err case %0d k=%0d: got cfg_err=%b busy=%b required %0d 0", i, k, cfg_err, busy, k == 0);
        end
      end
    end
  endtask

  // random geometry/modes, random ready, and config/start noise while busy that must be ignored
  task automatic test_random();
    px_t e;
    px_t q[$];
    int w, h, hb, vb, fr, md;
    logic [PW-1:0] col;
    logic fin;
    for (int it = 0; it < 8; it++) begin
      w = $urandom_range(1, 6);
      h = $urandom_range(1, 4);
      hb = $urandom_range(0, 3);
      vb = $urandom_range(0, 3);
      fr = $urandom_range(1, 3);
      md = $urandom_range(0, 7);
      col = PW'($urandom);
      q.delete();
      for (int f = 0; f < fr; f++)
        for (int yy = 0; yy < h; yy++)
          for (int xx = 0; xx < w; xx++) begin
            e.x = CW'(xx);
            e.y = CW'(yy);
            e.p = ref_pix(md, col, xx, yy);
            e.s = xx == 0 && yy == 0;
            e.e = xx == w - 1 && yy == h - 1;
            q.push_back(e);
          end
      setup(w, h, hb, vb, fr, md, col);
      ready = 1;
      kick();
      fin = 0;
      for (int k = 0; k < 3000 && !fin; k++) begin
        @(negedge clk);
        if (valid) begin
          n_chk++;
          if (q.size() == 0) begin
            n_fail++;
            $display("FAIL rnd_extra it=%0d: got pixel x=%0d y=%0d required none", it, x, y);
          end else begin
            e = q.pop_front();
            if ({x, y, pixel, sof, eof, lvalid, fvalid} !== {e.x, e.y, e.p, e.s, e.e, 2'b11}) begin
              n_fail++;
              $display("FAIL rnd_pixel it=%0d: got x=%0d y=%0d p=%h sof=%b eof=%b lv=%b fv=%b required x=%0d y=%0d p=%h sof=%b eof=%b", it, x, y, pixel, sof, eof, lvalid, fvalid, e.x, e.y, e.p, e.s, e.e);
            end
          end
        end
        if (done) fin = 1;
        else begin
          ready = $urandom_range(0, 3) != 0;
          start = busy && $urandom_range(0, 7) == 0;
          cfg_width = CW'($urandom);
          cfg_height = CW'($urandom);
          cfg_hblank = CW'($urandom);
          cfg_vblank = CW'($urandom);
          cfg_frames = FW'($urandom);
          mode = 3'($urandom);
          cfg_color = PW'($urandom);
        end
      end
      start = 0;
      ready = 1;
      n_chk++;
      if (!fin) begin n_fail++; $display("FAIL rnd_timeout it=%0d: got no done required done within 3000 cycles", it); end
      n_chk++;
      if (q.size() != 0) begin n_fail++; $display("FAIL rnd_missing it=%0d: got %0d pixels short required 0", it, q.size()); end
      n_chk++;
      if (frame_cnt !== FW'(fr)) begin n_fail++; $display("FAIL rnd_frame_cnt it=%0d: got %0d required %0d", it, frame_cnt, fr); end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_blanking();
    test_backpressure();
    test_patterns();
    test_stop();
    test_stop_vblank();
    test_cfg_err();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
